// File: rtl/fft_bar_scaler.sv
// fft_bar_scaler: converts NCH spectrum magnitudes into bar heights, using either a linear divide or a log scale.
// Ports: Clock, Reset (async, active-high); Start latches In/Div/Mode; In holds NCH magnitudes (channel i at [i*BW_IN +: BW_IN]);
// Div is the linear divisor; Mode selects 0 = linear, 1 = log; Out holds the bar heights (same packing, BW_OUT each);
// Busy is high while a conversion runs; End pulses for one cycle at completion.
// Optional macro FFT_BAR_PEAKHOLD_EN: each bar decays by at most one step per conversion instead of dropping.
module fft_bar_scaler #(
  parameter int BW_IN = 17,
  parameter int BW_OUT = 7,
  parameter int NCH = 2,
  parameter int SAT_TH = 16384,
  parameter int SAT_VAL = 96
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [NCH*BW_IN-1:0]  In,
  input  logic [7:0]            Div,
  input  logic                  Mode,
  output logic [NCH*BW_OUT-1:0] Out,
  output logic                  Busy,
  output logic                  End
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int NW = $clog2(BW_IN + 1);
  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;
  state_t state, state_nxt;
  logic [NCH*BW_IN-1:0] in_r, in_nxt;
  logic [7:0] div_r, div_nxt;
  logic mode_r, mode_nxt;
  logic [CW-1:0] ch, ch_nxt;
  logic [7:0] rem, rem_nxt;
  logic [BW_IN-1:0] q, q_nxt;
  logic [NW-1:0] cnt, cnt_nxt;
  logic [NCH*BW_OUT-1:0] shadow, shadow_nxt, out_nxt;
  logic busy_nxt, end_nxt;
  logic [BW_IN-1:0] x;
  logic [8:0] trial;
  logic bitq, done_ch;
  logic [BW_OUT-1:0] res;
  function automatic logic [BW_OUT-1:0] clamp(input int v);
    return v > SAT_VAL ? BW_OUT'(SAT_VAL) : BW_OUT'(v);
  endfunction
  // 4*msb_position + the two bits below the msb; shifting left by 2 first zero-fills when msb < 2
  function automatic int log_val(input logic [BW_IN-1:0] v);
    int p;
    logic [BW_IN+1:0] s;
    p = 0;
    for (int i = 0; i < BW_IN; i++) if (v[i]) p = i;
    s = {v, 2'b00} >> p;
    return v == '0 ? 0 : 4 * p + int'(s[1:0]);
  endfunction
`ifdef FFT_BAR_PEAKHOLD_EN
  function automatic logic [NCH*BW_OUT-1:0] settle(input logic [NCH*BW_OUT-1:0] fresh, prev);
    logic [BW_OUT-1:0] r, d;
    settle = '0;
    for (int i = 0; i < NCH; i++) begin
      r = fresh[i*BW_OUT +: BW_OUT];
      d = prev[i*BW_OUT +: BW_OUT] == '0 ? '0 : prev[i*BW_OUT +: BW_OUT] - 1'b1;
      settle[i*BW_OUT +: BW_OUT] = r > d ? r : d;
    end
  endfunction
`endif
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      in_r <= '0;
      div_r <= '0;
      mode_r <= 1'b0;
      ch <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      shadow <= '0;
      Out <= '0;
      Busy <= 1'b0;
      End <= 1'b0;
    end else begin
      state <= state_nxt;
      in_r <= in_nxt;
      div_r <= div_nxt;
      mode_r <= mode_nxt;
      ch <= ch_nxt;
      rem <= rem_nxt;
      q <= q_nxt;
      cnt <= cnt_nxt;
      shadow <= shadow_nxt;
      Out <= out_nxt;
      Busy <= busy_nxt;
      End <= end_nxt;
    end
  always_comb begin
    state_nxt = state;
    in_nxt = in_r;
    div_nxt = div_r;
    mode_nxt = mode_r;
    ch_nxt = ch;
    rem_nxt = rem;
    q_nxt = q;
    cnt_nxt = cnt;
    shadow_nxt = shadow;
    out_nxt = Out;
    busy_nxt = Busy;
    end_nxt = 1'b0;
    res = '0;
    done_ch = 1'b0;
    x = in_r[int'(ch)*BW_IN +: BW_IN];
    // restoring step: the dividend shifts out of q's top while quotient bits shift into its bottom
    trial = {rem, q[BW_IN-1]};
    bitq = trial >= {1'b0, div_r};
    case (state)
      IDLE: if (Start) begin
        in_nxt = In;
        div_nxt = Div;
        mode_nxt = Mode;
        ch_nxt = '0;
        busy_nxt = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: if (int'(x) >= SAT_TH || (!mode_r && div_r == '0)) begin
        res = BW_OUT'(SAT_VAL);
        done_ch = 1'b1;
      end else if (mode_r) begin
        res = clamp(log_val(x));
        done_ch = 1'b1;
      end else begin
        rem_nxt = '0;
        q_nxt = x;
        cnt_nxt = '0;
        state_nxt = DIV;
      end
      DIV: begin
        rem_nxt = bitq ? 8'(trial - {1'b0, div_r}) : trial[7:0];
        q_nxt = {q[BW_IN-2:0], bitq};
        cnt_nxt = cnt + 1'b1;
        if (cnt == NW'(BW_IN - 1)) begin
          res = clamp(int'(q_nxt));
          done_ch = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
    endcase
    if (done_ch) begin
      shadow_nxt[int'(ch)*BW_OUT +: BW_OUT] = res;
      ch_nxt = ch + 1'b1;
      state_nxt = CHECK;
      if (ch == CW'(NCH - 1)) begin
        state_nxt = DONE;
        busy_nxt = 1'b0;
        end_nxt = 1'b1;
`ifdef FFT_BAR_PEAKHOLD_EN
        out_nxt = settle(shadow_nxt, Out);
`else
        out_nxt = shadow_nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fft_bar_scaler.sv
// tb_fft_bar_scaler: random and directed conversions compared against a cycle-count/arithmetic model.
module tb_fft_bar_scaler;
  localparam int BW_IN = 17;
  localparam int BW_OUT = 7;
  localparam int NCH = 2;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic [NCH*BW_IN-1:0] In = '0;
  logic [7:0] Div = '0;
  logic Mode = 1'b0;
  logic [NCH*BW_OUT-1:0] Out;
  logic Busy, End;
  int tests = 0;
  int fails = 0;
  bit m_busy = 1'b0;
  bit m_end = 1'b0;
  int m_left = 0;
  int m_out[NCH];
  int m_pend[NCH];
  fft_bar_scaler dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .In(In), .Div(Div),
    .Mode(Mode), .Out(Out), .Busy(Busy), .End(End)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int f_res(input int v, input int d, input bit m);
    int p, r;
    if (v >= 16384 || (!m && d == 0)) return 96;
    if (m) begin
      if (v == 0) return 0;
      p = 0;
      while ((v >> (p + 1)) != 0) p++;
      r = 4 * p + (((v * 4) >> p) & 3);
    end else r = v / d;
    return r > 96 ? 96 : r;
  endfunction
  function automatic int f_cyc(input int v, input int d, input bit m);
    return (v >= 16384 || m || d == 0) ? 1 : 1 + BW_IN;
  endfunction
  function automatic int f_next(input int fresh, input int prev);
`ifdef FFT_BAR_PEAKHOLD_EN
    int dec;
    dec = prev > 0 ? prev - 1 : 0;
    return fresh > dec ? fresh : dec;
`else
    return prev >= 0 ? fresh : fresh;
`endif
  endfunction
  function automatic logic [BW_IN-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return BW_IN'($urandom_range(1, 255));
      2: return BW_IN'($urandom_range(256, 16383));
      3: return BW_IN'($urandom_range(16383, 16384));
      4: return BW_IN'($urandom_range(16385, 131071));
      default: return BW_IN'($urandom_range(0, 131071));
    endcase
  endfunction
  // Model: conversion accepted when neither busy nor in its completion cycle; End lands L-1 edges later.
  always @(posedge Clock or posedge Reset) begin : model
    int l;
    int v;
    if (Reset) begin
      m_busy <= 1'b0;
      m_end <= 1'b0;
      m_left <= 0;
      for (int i = 0; i < NCH; i++) m_out[i] <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_end <= 1'b1;
        for (int i = 0; i < NCH; i++) m_out[i] <= f_next(m_pend[i], m_out[i]);
      end
    end else if (m_end) m_end <= 1'b0;
    else if (Start) begin
      l = 1;
      for (int i = 0; i < NCH; i++) begin
        v = int'(In[i*BW_IN +: BW_IN]);
        m_pend[i] <= f_res(v, int'(Div), Mode);
        l += f_cyc(v, int'(Div), Mode);
      end
      m_busy <= 1'b1;
      m_left <= l - 1;
    end
  end
  always @(negedge Clock) begin
    check("busy", int'(Busy), int'(m_busy));
    check("end", int'(End), int'(m_end));
    for (int i = 0; i < NCH; i++) check("out", int'(Out[i*BW_OUT +: BW_OUT]), m_out[i]);
  end
  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask
  task automatic run(input int a, input int b, input int d, input bit m, input int e0, input int e1, input int el);
    int n, nb;
    @(negedge Clock);
    In = {BW_IN'(b), BW_IN'(a)};
    Div = 8'(d);
    Mode = m;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    nb = 0;
    while (!End && n < 200) begin
      if (Busy) nb++;
      @(negedge Clock);
      n++;
    end
    check("latency", n + 1, el);
    check("busy_cycles", nb, el - 1);
    check("ch0", int'(Out[BW_OUT-1:0]), e0);
    check("ch1", int'(Out[2*BW_OUT-1:BW_OUT]), e1);
    @(negedge Clock);
    check("end_width", int'(End), 0);
  endtask
  initial begin
    int n, ends;
    repeat (3) @(negedge Clock);
    check("rst_out", int'(Out), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_end", int'(End), 0);
    Reset = 1'b0;
    run(4250, 0, 85, 1'b0, 50, 0, 37);
    do_reset();
    run(20000, 16383, 85, 1'b0, 96, 96, 20);
    do_reset();
    run(1000, 1, 0, 1'b1, 39, 0, 3);
    do_reset();
    run(5, 5, 0, 1'b0, 96, 96, 3);
    do_reset();
    run(4250, 0, 85, 1'b0, 50, 0, 37);
`ifdef FFT_BAR_PEAKHOLD_EN
    run(850, 0, 85, 1'b0, 49, 0, 37);
`else
    run(850, 0, 85, 1'b0, 10, 0, 37);
`endif
    run(5950, 0, 85, 1'b0, 70, 0, 37);
    // reset in the middle of a division, then no stray End and a clean restart
    @(negedge Clock);
    In = {BW_IN'(0), BW_IN'(4250)};
    Div = 8'd85;
    Mode = 1'b0;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (6) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_out", int'(Out), 0);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_end", int'(End), 0);
    Reset = 1'b0;
    ends = 0;
    repeat (40) begin
      @(negedge Clock);
      if (End) ends++;
    end
    check("no_end_after_rst", ends, 0);
    run(1000, 1, 0, 1'b1, 39, 0, 3);
    // random conversions; inputs churn and Start is pulsed while busy
    repeat (150) begin
      @(negedge Clock);
      In = {rnd(), rnd()};
      Div = $urandom_range(0, 9) == 0 ? 8'd0 : 8'($urandom_range(1, 255));
      Mode = 1'($urandom_range(0, 1));
      Start = 1'b1;
      n = 0;
      ends = 0;
      do begin
        @(negedge Clock);
        n++;
        if (End) ends++;
        In = {rnd(), rnd()};
        Div = 8'($urandom_range(0, 255));
        Mode = 1'($urandom_range(0, 1));
        Start = Busy ? 1'($urandom_range(0, 1)) : 1'b0;
      end while (!End && n < 100);
      check("rand_one_end", ends, 1);
      Start = 1'b0;
    end
    @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
